// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder_pkg
//  Description : Shared types and helpers for the memory responder: FSM
//                state encoding and the core-index width function.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    // Transaction FSM, explicitly 2 bits wide with fixed encodings
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Width of a core index; never narrower than one bit
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder_rr_arbiter
//  Description : Combinational round-robin selector. Picks the first
//                requesting core searching upward (cyclically) from the core
//                after the last one granted.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder_rr_arbiter
    import mem_responder_pkg::*;
#(
    parameter int CORE_NUM = 4,
    parameter int IDX_W    = idx_width(CORE_NUM)
) (
    input  logic [CORE_NUM-1:0] i_request,
    input  logic [IDX_W-1:0]    i_last_grant,
    output logic [IDX_W-1:0]    o_grant,
    output logic                o_any_req
);

    logic [IDX_W-1:0] w_grant;
    logic             w_any;
    int               w_idx;

    // Walk offsets from farthest to nearest so the nearest requester wins
    always_comb begin
        w_grant = '0;
        w_any   = 1'b0;
        w_idx   = 0;
        for (int k = CORE_NUM; k >= 1; k--) begin
            w_idx = (int'(i_last_grant) + k) % CORE_NUM;
            if (i_request[IDX_W'(w_idx)]) begin
                w_grant = IDX_W'(w_idx);
                w_any   = 1'b1;
            end
        end
    end

    assign o_grant   = w_grant;
    assign o_any_req = w_any;

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Memory-side responder for per-core data requests. Serves one
//                core at a time (round-robin) on a single-port synchronous
//                RAM and returns a one-cycle response pulse with read data.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int CORE_NUM    = 4,
    parameter int ADDR_WIDTH  = 16,
    parameter int RAM_LATENCY = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [CORE_NUM-1:0]              request,
    input  logic [CORE_NUM-1:0]              wren,
    input  logic [CORE_NUM*WIDTH-1:0]        address,
    input  logic [CORE_NUM*WIDTH-1:0]        writedata,
    output logic [CORE_NUM-1:0]              response,
    output logic [WIDTH-1:0]                 readdata,
    output logic                             ram_en,
    output logic                             ram_wren,
    output logic [ADDR_WIDTH-1:0]            ram_addr,
    output logic [WIDTH-1:0]                 ram_wdata,
    input  logic [WIDTH-1:0]                 ram_rdata,
    output logic                             busy,
    output logic [idx_width(CORE_NUM)-1:0]   grant_idx
);

    localparam int c_idx_w = idx_width(CORE_NUM);
    localparam int c_cnt_w = $clog2(RAM_LATENCY + 1);

    state_t                r_state, w_state_nxt;
    logic [c_idx_w-1:0]    r_gidx, w_gidx_nxt;
    logic [c_idx_w-1:0]    r_last, w_last_nxt;
    logic                  r_is_wr, w_is_wr_nxt;
    logic [c_cnt_w-1:0]    r_cnt, w_cnt_nxt;
    logic [CORE_NUM-1:0]   r_response, w_response_nxt;
    logic [WIDTH-1:0]      r_readdata, w_readdata_nxt;
    logic                  r_ram_en, w_ram_en_nxt;
    logic                  r_ram_wren, w_ram_wren_nxt;
    logic [ADDR_WIDTH-1:0] r_ram_addr, w_ram_addr_nxt;
    logic [WIDTH-1:0]      r_ram_wdata, w_ram_wdata_nxt;
    logic                  r_busy, w_busy_nxt;
    logic [c_idx_w-1:0]    w_arb_grant;
    logic                  w_arb_any;
    int                    w_base;

    mem_responder_rr_arbiter #(
        .CORE_NUM (CORE_NUM),
        .IDX_W    (c_idx_w)
    ) u_arb (
        .i_request    (request),
        .i_last_grant (r_last),
        .o_grant      (w_arb_grant),
        .o_any_req    (w_arb_any)
    );

    // Next-state and next-output logic; every output is a register, so this
    // block computes what each one holds in the following cycle
    always_comb begin
        w_state_nxt     = r_state;
        w_gidx_nxt      = r_gidx;
        w_last_nxt      = r_last;
        w_is_wr_nxt     = r_is_wr;
        w_cnt_nxt       = r_cnt;
        w_readdata_nxt  = r_readdata;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_wdata_nxt = r_ram_wdata;
        w_response_nxt  = '0;
        w_ram_en_nxt    = 1'b0;
        w_ram_wren_nxt  = 1'b0;
        w_base          = int'(w_arb_grant) * WIDTH;
        case (r_state)
            S_IDLE: begin
                if (w_arb_any) begin
                    // The RAM strobe is raised here so it is visible in ISSUE
                    w_gidx_nxt      = w_arb_grant;
                    w_last_nxt      = w_arb_grant;
                    w_is_wr_nxt     = wren[w_arb_grant];
                    w_ram_en_nxt    = 1'b1;
                    w_ram_wren_nxt  = wren[w_arb_grant];
                    w_ram_addr_nxt  = address[w_base +: ADDR_WIDTH];
                    w_ram_wdata_nxt = writedata[w_base +: WIDTH];
                    w_state_nxt     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (r_is_wr) begin
                    w_response_nxt = CORE_NUM'(1) << r_gidx;
                    w_state_nxt    = S_RESP;
                end else begin
                    w_cnt_nxt   = c_cnt_w'(RAM_LATENCY);
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                w_cnt_nxt = r_cnt - 1'b1;
                if (r_cnt == c_cnt_w'(1)) begin
                    w_readdata_nxt = ram_rdata;
                    w_response_nxt = CORE_NUM'(1) << r_gidx;
                    w_state_nxt    = S_RESP;
                end
            end
            S_RESP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        w_busy_nxt = (w_state_nxt != S_IDLE);
    end

    // State and registered outputs; reset drops any transaction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_gidx      <= '0;
            r_last      <= c_idx_w'(CORE_NUM - 1);
            r_is_wr     <= 1'b0;
            r_cnt       <= '0;
            r_response  <= '0;
            r_readdata  <= '0;
            r_ram_en    <= 1'b0;
            r_ram_wren  <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_busy      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_gidx      <= w_gidx_nxt;
            r_last      <= w_last_nxt;
            r_is_wr     <= w_is_wr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_response  <= w_response_nxt;
            r_readdata  <= w_readdata_nxt;
            r_ram_en    <= w_ram_en_nxt;
            r_ram_wren  <= w_ram_wren_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign response  = r_response;
    assign readdata  = r_readdata;
    assign ram_en    = r_ram_en;
    assign ram_wren  = r_ram_wren;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign busy      = r_busy;
    assign grant_idx = r_gidx;

endmodule
`default_nettype wire
